// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Walks a 4-input combinational function through all 16 input codes,
//   captures its truth table and compares it with a golden table latched
//   when the sweep starts.
//
//   Ports
//     clk             in   rising-edge clock
//     aresetn         in   asynchronous active-low reset
//     start           in   sweep request, honoured only while idle
//     expected[15:0]  in   golden truth table, bit k = expected f for x=k
//     x[3:0]          out  registered stimulus for the function under test
//     f               in   function output for the current x
//     busy            out  high while a sweep is running
//     done            out  one-cycle pulse when a sweep completes
//     mask[15:0]      out  captured truth table, bit k = f sampled for x=k
//     mismatch_cnt    out  number of bits where mask differs from golden
//     match           out  completed sweep had no mismatches
//     first_bad[3:0]  out  lowest x that mismatched
//     first_bad_valid out  at least one mismatch was seen
//
//   Each input code occupies SETTLE clock cycles; f is sampled on the last
//   edge of that window. SETTLE-1 of those cycles are spent in ST_SETTLE and
//   the final one in ST_SAMPLE, so with SETTLE=1 the settle state is skipped.
module truth_table_sweeper #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [15:0] expected,
    output logic [3:0]  x,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic [15:0] mask,
    output logic [4:0]  mismatch_cnt,
    output logic        match,
    output logic [3:0]  first_bad,
    output logic        first_bad_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Cycles spent in ST_SETTLE before the sampling cycle.
    localparam logic [3:0] WAIT_RELOAD = 4'(SETTLE - 1);
    // State entered whenever a new x is driven.
    localparam logic [1:0] ST_STEP     = (SETTLE == 1) ? ST_SAMPLE : ST_SETTLE;
    localparam logic [4:0] CNT_MAX     = 5'h10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] exp_q, exp_d;
    logic [3:0]  x_q, x_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] mask_q, mask_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        match_q, match_d;
    logic [3:0]  fb_q, fb_d;
    logic        fbv_q, fbv_d;

    logic        miss;
    logic [4:0]  cnt_inc;

    always_comb begin
        miss    = f ^ exp_q[x_q];
        // Saturating increment: the count can never exceed 16.
        cnt_inc = (miss && (cnt_q != CNT_MAX)) ? cnt_q + 5'd1 : cnt_q;

        state_d = state_q;
        wait_d  = wait_q;
        exp_d   = exp_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        fb_d    = fb_q;
        fbv_d   = fbv_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    mask_d  = 16'h0000;
                    cnt_d   = 5'd0;
                    match_d = 1'b0;
                    fb_d    = 4'd0;
                    fbv_d   = 1'b0;
                    busy_d  = 1'b1;
                    x_d     = 4'd0;
                    wait_d  = WAIT_RELOAD;
                    state_d = ST_STEP;
                end
            end
            ST_SETTLE: begin
                if (wait_q <= 4'd1) begin
                    wait_d  = 4'd0;
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                mask_d[x_q] = f;
                cnt_d       = cnt_inc;
                if (miss && !fbv_q) begin
                    fb_d  = x_q;
                    fbv_d = 1'b1;
                end
                if (x_q == 4'd15) begin
                    x_d     = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    match_d = (cnt_inc == 5'd0);
                    state_d = ST_DONE;
                end else begin
                    x_d     = x_q + 4'd1;
                    wait_d  = WAIT_RELOAD;
                    state_d = ST_STEP;
                end
            end
            default: begin
                // ST_DONE: one cycle, start deliberately not looked at.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
            exp_q   <= 16'h0000;
            x_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= 16'h0000;
            cnt_q   <= 5'd0;
            match_q <= 1'b0;
            fb_q    <= 4'd0;
            fbv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            exp_q   <= exp_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            fb_q    <= fb_d;
            fbv_q   <= fbv_d;
        end
    end

    assign x               = x_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign mask            = mask_q;
    assign mismatch_cnt    = cnt_q;
    assign match           = match_q;
    assign first_bad       = fb_q;
    assign first_bad_valid = fbv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper. Two instances: index 0 with SETTLE=1
// driving an instantaneous function, index 1 with SETTLE=3 driving a
// function whose output lags x by two clock cycles.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rstn_v;
    logic [1:0]  start_v;
    logic [15:0] exp_v   [2];
    logic [15:0] tt_v    [2];
    logic [1:0]  fzero_v;
    logic [3:0]  x_v     [2];
    logic [1:0]  busy_v, done_v, match_v, fbv_v;
    logic [15:0] mask_v  [2];
    logic [4:0]  cnt_v   [2];
    logic [3:0]  fb_v    [2];
    logic        f0, f1;
    logic [3:0]  d1, d2;

    int total = 0;
    int bad   = 0;

    truth_table_sweeper #(.SETTLE(1)) dut0 (
        .clk(clk), .aresetn(rstn_v[0]), .start(start_v[0]), .expected(exp_v[0]),
        .x(x_v[0]), .f(f0), .busy(busy_v[0]), .done(done_v[0]), .mask(mask_v[0]),
        .mismatch_cnt(cnt_v[0]), .match(match_v[0]), .first_bad(fb_v[0]),
        .first_bad_valid(fbv_v[0])
    );

    truth_table_sweeper #(.SETTLE(3)) dut1 (
        .clk(clk), .aresetn(rstn_v[1]), .start(start_v[1]), .expected(exp_v[1]),
        .x(x_v[1]), .f(f1), .busy(busy_v[1]), .done(done_v[1]), .mask(mask_v[1]),
        .mismatch_cnt(cnt_v[1]), .match(match_v[1]), .first_bad(fb_v[1]),
        .first_bad_valid(fbv_v[1])
    );

    // Function models: instance 0 reacts immediately, instance 1 sees x
    // through a two-stage pipeline.
    always_ff @(posedge clk) begin
        d1 <= x_v[1];
        d2 <= d1;
    end

    always_comb begin
        f0 = fzero_v[0] ? 1'b0 : tt_v[0][x_v[0]];
        f1 = fzero_v[1] ? 1'b0 : tt_v[1][d2];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: the captured table is just the function's table; the
    // comparison figures come from the XOR with the golden table.
    function automatic void model(input logic [15:0] tt, input logic [15:0] ex,
                                  output logic [15:0] m, output logic [4:0] cnt,
                                  output logic [3:0] fb, output logic fbv);
        logic [15:0] diff;
        m    = tt;
        diff = tt ^ ex;
        cnt  = 5'd0;
        fb   = 4'd0;
        fbv  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (diff[k]) begin
                cnt = cnt + 5'd1;
                if (!fbv) begin
                    fb  = 4'(k);
                    fbv = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_results(input int i, input logic [15:0] tt, input logic [15:0] ex,
                                 input string tag);
        logic [15:0] m;
        logic [4:0]  c;
        logic [3:0]  fb;
        logic        fbv;
        model(tt, ex, m, c, fb, fbv);
        chk({tag, ".mask"},  32'(mask_v[i]), 32'(m));
        chk({tag, ".cnt"},   32'(cnt_v[i]),  32'(c));
        chk({tag, ".match"}, 32'(match_v[i]), 32'(c == 5'd0));
        chk({tag, ".fbv"},   32'(fbv_v[i]),  32'(fbv));
        chk({tag, ".fb"},    32'(fb_v[i]),   32'(fb));
    endtask

    task automatic check_cleared(input int i, input string tag);
        chk({tag, ".x"},     32'(x_v[i]),     32'd0);
        chk({tag, ".busy"},  32'(busy_v[i]),  32'd0);
        chk({tag, ".done"},  32'(done_v[i]),  32'd0);
        chk({tag, ".mask"},  32'(mask_v[i]),  32'd0);
        chk({tag, ".cnt"},   32'(cnt_v[i]),   32'd0);
        chk({tag, ".match"}, 32'(match_v[i]), 32'd0);
        chk({tag, ".fb"},    32'(fb_v[i]),    32'd0);
        chk({tag, ".fbv"},   32'(fbv_v[i]),   32'd0);
    endtask

    // One full sweep. hold keeps start high throughout, pulse raises start
    // while x==9, scramble changes expected every cycle after acceptance.
    task automatic sweep(input int i, input logic [15:0] tt, input logic fz,
                         input logic [15:0] ex, input bit hold, input bit pulse,
                         input bit scramble, input string tag);
        int s;
        int n;
        bit got;
        logic [15:0] eff;
        s   = (i == 0) ? 1 : 3;
        eff = fz ? 16'h0000 : tt;
        @(negedge clk);
        tt_v[i]    = tt;
        fzero_v[i] = fz;
        exp_v[i]   = ex;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".e0_busy"}, 32'(busy_v[i]), 32'd1);
        chk({tag, ".e0_x"},    32'(x_v[i]),    32'd0);
        chk({tag, ".e0_mask"}, 32'(mask_v[i]), 32'd0);
        chk({tag, ".e0_cnt"},  32'(cnt_v[i]),  32'd0);
        chk({tag, ".e0_fbv"},  32'(fbv_v[i]),  32'd0);
        if (!hold) start_v[i] = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 16 * s + 8) begin
            @(posedge clk);
            #1;
            n++;
            if (done_v[i]) begin
                got = 1'b1;
            end else begin
                chk({tag, ".x_step"}, 32'(x_v[i]), 32'(n / s));
                chk({tag, ".busy"},   32'(busy_v[i]), 32'd1);
                if (scramble) exp_v[i] = 16'($urandom);
                if (pulse) start_v[i] = (x_v[i] == 4'd9);
            end
        end
        chk({tag, ".done_seen"}, 32'(got), 32'd1);
        chk({tag, ".latency"},   32'(n),   32'(16 * s));
        chk({tag, ".end_x"},     32'(x_v[i]),    32'd0);
        chk({tag, ".end_busy"},  32'(busy_v[i]), 32'd0);
        check_results(i, eff, ex, tag);
        $display("sweep %s inst=%0d tt=%04h ex=%04h mask=%04h cnt=%0d match=%0d fb=%0d fbv=%0d lat=%0d",
                 tag, i, eff, ex, mask_v[i], cnt_v[i], match_v[i], fb_v[i], fbv_v[i], n);
        // DONE cycle: a held start must not be accepted here.
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, 32'(done_v[i]), 32'd0);
        chk({tag, ".post_busy"},  32'(busy_v[i]), 32'd0);
        start_v[i] = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".idle_busy"}, 32'(busy_v[i]), 32'd0);
        check_results(i, eff, ex, {tag, ".hold"});
    endtask

    task automatic reset_mid_sweep(input string tag);
        int n;
        int dn;
        @(negedge clk);
        tt_v[0]    = 16'hD073;
        fzero_v[0] = 1'b0;
        exp_v[0]   = 16'h0F0F;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        n = 0;
        while (x_v[0] != 4'd7 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".reach_x7"}, 32'(x_v[0]), 32'd7);
        #2;
        rstn_v[0] = 1'b0;
        #1;
        check_cleared(0, {tag, ".async"});
        @(negedge clk);
        @(negedge clk);
        rstn_v[0] = 1'b1;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done_v[0] || busy_v[0]) dn++;
        end
        chk({tag, ".no_done"}, 32'(dn), 32'd0);
        $display("reset %s inst=0 aborted at x=7", tag);
    endtask

    initial begin
        logic [15:0] tt;
        logic [15:0] ex;
        rstn_v  = 2'b00;
        start_v = 2'b00;
        fzero_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            exp_v[i] = 16'h0000;
            tt_v[i]  = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1;
        check_cleared(0, "rst0");
        check_cleared(1, "rst1");
        @(negedge clk);
        rstn_v = 2'b11;

        sweep(0, 16'hD073, 1'b0, 16'hD073, 1'b0, 1'b0, 1'b0, "s1_pass");
        sweep(0, 16'hD073, 1'b0, 16'hD072, 1'b0, 1'b0, 1'b0, "s2_bit0");
        sweep(0, 16'hD073, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, "s3_all");
        sweep(1, 16'hD073, 1'b0, 16'hD073, 1'b0, 1'b0, 1'b1, "s4_slow");
        reset_mid_sweep("s5");
        sweep(0, 16'hD073, 1'b0, 16'hD0F3, 1'b0, 1'b0, 1'b0, "s5_after");
        sweep(0, 16'h1234, 1'b0, 16'h1230, 1'b1, 1'b0, 1'b0, "s6_hold");
        sweep(0, 16'hBEEF, 1'b0, 16'hBEAF, 1'b0, 1'b1, 1'b1, "s6_pulse");
        sweep(1, 16'h8001, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, "s6_hold_slow");

        for (int r = 0; r < 12; r++) begin
            tt = 16'($urandom);
            case (r % 3)
                0:       ex = tt;
                1:       ex = tt ^ (16'h0001 << $urandom_range(15, 0));
                default: ex = 16'($urandom);
            endcase
            sweep(r % 2, tt, (r == 7), ex, 1'b0, ($urandom_range(1, 0) == 1),
                  ($urandom_range(1, 0) == 1), $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
